// File: rtl/ff_fifo_any_depth_flags.sv
// Single-clock show-ahead flip-flop FIFO for any depth >= 2, with occupancy
// count, programmable almost-full/almost-empty and sticky error flags.
module ff_fifo_any_depth_flags #(
  parameter int width            = 64,
  parameter int depth            = 10,
  parameter int almost_full_lvl  = depth - 2,
  parameter int almost_empty_lvl = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           write_data,
  input  logic                       clr_err,
  output logic [width-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);

  generate
    if (depth < 2) begin : g_bad_depth
      $error("ff_fifo_any_depth_flags: depth must be >= 2");
    end
    if ((almost_full_lvl < 1) || (almost_full_lvl > depth)) begin : g_bad_af
      $error("ff_fifo_any_depth_flags: almost_full_lvl out of range");
    end
    if ((almost_empty_lvl < 0) || (almost_empty_lvl >= depth)) begin : g_bad_ae
      $error("ff_fifo_any_depth_flags: almost_empty_lvl out of range");
    end
  endgenerate

  logic [width-1:0] mem_r [depth];
  logic [aw-1:0]    wr_ptr_r;
  logic [aw-1:0]    rd_ptr_r;
  logic [cw-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             empty_s;
  logic             full_s;

  // Occupancy flags and accept qualifiers, all decoded from the count register.
  always_comb begin
    empty_s   = (count_r == cw'(0));
    full_s    = (count_r == cw'(depth));
    push_ok_s = push & (~full_s | pop);
    pop_ok_s  = pop & ~empty_s;
  end

  // Storage is deliberately left unreset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= write_data;
    end
  end

  // Pointers wrap explicitly at depth-1 so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= (wr_ptr_r == aw'(depth - 1)) ? aw'(0) : wr_ptr_r + aw'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= (rd_ptr_r == aw'(depth - 1)) ? aw'(0) : rd_ptr_r + aw'(1);
      end
    end
  end

  // Occupancy count tracks net accepted pushes minus pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + cw'(1);
        2'b01:   count_r <= count_r - cw'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push & full_s & ~pop) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (pop & empty_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  // Output mapping; head entry is shown combinationally.
  always_comb begin
    read_data    = mem_r[rd_ptr_r];
    empty        = empty_s;
    full         = full_s;
    almost_empty = (count_r <= cw'(almost_empty_lvl));
    almost_full  = (count_r >= cw'(almost_full_lvl));
    count        = count_r;
    overflow     = overflow_r;
    underflow    = underflow_r;
  end

endmodule

// File: tb/tb_ff_fifo_any_depth_flags.sv
// Directed self-checking bench for ff_fifo_any_depth_flags (depth 10, width 8).
module tb_ff_fifo_any_depth_flags;

  localparam int W = 8;
  localparam int D = 10;

  logic         clk;
  logic         rst_n;
  logic         push;
  logic         pop;
  logic [W-1:0] write_data;
  logic         clr_err;
  logic [W-1:0] read_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [3:0]   count;
  logic         overflow;
  logic         underflow;

  int total = 0;
  int bad   = 0;

  ff_fifo_any_depth_flags #(.width(W), .depth(D)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .write_data(write_data),
    .clr_err(clr_err), .read_data(read_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock with the given request; outputs are stable #1 after the edge.
  task automatic do_cycle(input logic p, input logic q, input logic [W-1:0] d, input logic c);
    push = p; pop = q; write_data = d; clr_err = c;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  task automatic fill_1_to_10();
    for (int i = 1; i <= D; i++) do_cycle(1'b1, 1'b0, W'(i), 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; write_data = '0; clr_err = 1'b0;
    #3;
    total++;
    if ({empty, full, almost_empty, almost_full, overflow, underflow} !== 6'b101000) begin
      bad++; $display("FAIL reset_flags: got %b want 101000",
                      {empty, full, almost_empty, almost_full, overflow, underflow});
    end
    total++;
    if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= D; i++) begin
      do_cycle(1'b1, 1'b0, W'(i), 1'b0);
      total++;
      if (count !== 4'(i)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, i); end
      total++;
      if ({full, almost_full, almost_empty, empty} !== {(i == D), (i >= 8), (i <= 2), 1'b0}) begin
        bad++; $display("FAIL fill_flags: got %b want %b at count %0d",
                        {full, almost_full, almost_empty, empty},
                        {(i == D), (i >= 8), (i <= 2), 1'b0}, i);
      end
      total++;
      if (read_data !== 8'h01) begin bad++; $display("FAIL fill_head: got %h want 01", read_data); end
    end
    for (int i = 1; i <= D; i++) begin
      total++;
      if (read_data !== W'(i)) begin bad++; $display("FAIL drain_data: got %h want %h", read_data, W'(i)); end
      do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
      total++;
      if (count !== 4'(D - i)) begin bad++; $display("FAIL drain_count: got %0d want %0d", count, D - i); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, 8'h30 + W'(i), 1'b0);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (read_data !== 8'h30 + W'(i)) begin
        bad++; $display("FAIL wrap_pre: got %h want %h", read_data, 8'h30 + W'(i));
      end
      do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
    for (int i = 0; i < D; i++) do_cycle(1'b1, 1'b0, 8'h11 + W'(i), 1'b0);
    total++;
    if (full !== 1'b1) begin bad++; $display("FAIL wrap_full: got %b want 1", full); end
    for (int i = 0; i < D; i++) begin
      total++;
      if (read_data !== 8'h11 + W'(i)) begin
        bad++; $display("FAIL wrap_data: got %h want %h", read_data, 8'h11 + W'(i));
      end
      do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
    total++;
    if (count !== 4'd0) begin bad++; $display("FAIL wrap_count: got %0d want 0", count); end
  endtask

  task automatic test_full_simul();
    logic [W-1:0] exp;
    fill_1_to_10();
    total++;
    if (read_data !== 8'h01) begin bad++; $display("FAIL fs_head: got %h want 01", read_data); end
    do_cycle(1'b1, 1'b1, 8'hAA, 1'b0);
    total++;
    if ({count, overflow, full} !== {4'd10, 1'b0, 1'b1}) begin
      bad++; $display("FAIL fs_state: got cnt=%0d ov=%b full=%b want 10 0 1", count, overflow, full);
    end
    for (int k = 0; k <= 9; k++) begin
      exp = (k == 9) ? 8'hAA : 8'h02 + W'(k);
      total++;
      if (read_data !== exp) begin bad++; $display("FAIL fs_data: got %h want %h", read_data, exp); end
      do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL fs_empty: got %b want 1", empty); end
  endtask

  task automatic test_errors();
    fill_1_to_10();
    do_cycle(1'b1, 1'b0, 8'hBB, 1'b0);
    total++;
    if ({count, overflow, underflow, read_data} !== {4'd10, 1'b1, 1'b0, 8'h01}) begin
      bad++; $display("FAIL ovf: got cnt=%0d ov=%b un=%b rd=%h want 10 1 0 01",
                      count, overflow, underflow, read_data);
    end
    for (int i = 1; i <= D; i++) begin
      total++;
      if (read_data !== W'(i)) begin bad++; $display("FAIL ovf_data: got %h want %h", read_data, W'(i)); end
      do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
    do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    total++;
    if ({count, underflow, overflow} !== {4'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL unf: got cnt=%0d un=%b ov=%b want 0 1 1", count, underflow, overflow);
    end
    do_cycle(1'b0, 1'b1, 8'h00, 1'b1);
    total++;
    if ({underflow, overflow} !== 2'b10) begin
      bad++; $display("FAIL clr_vs_err: got un/ov=%b want 10", {underflow, overflow});
    end
    do_cycle(1'b0, 1'b0, 8'h00, 1'b1);
    total++;
    if ({underflow, overflow} !== 2'b00) begin
      bad++; $display("FAIL clr_err: got un/ov=%b want 00", {underflow, overflow});
    end
  endtask

  task automatic test_empty_simul();
    do_cycle(1'b1, 1'b1, 8'h55, 1'b0);
    total++;
    if ({count, underflow, empty, read_data} !== {4'd1, 1'b1, 1'b0, 8'h55}) begin
      bad++; $display("FAIL es: got cnt=%0d un=%b empty=%b rd=%h want 1 1 0 55",
                      count, underflow, empty, read_data);
    end
    do_cycle(1'b0, 1'b1, 8'h00, 1'b1);
    total++;
    if ({count, underflow} !== {4'd0, 1'b0}) begin
      bad++; $display("FAIL es_drain: got cnt=%0d un=%b want 0 0", count, underflow);
    end
  endtask

  task automatic test_async_reset();
    do_cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 8'h60 + W'(i), 1'b0);
    total++;
    if ({count, underflow} !== {4'd5, 1'b1}) begin
      bad++; $display("FAIL ar_pre: got cnt=%0d un=%b want 5 1", count, underflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({count, empty, overflow, underflow, almost_empty} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL ar_now: got cnt=%0d e=%b ov=%b un=%b ae=%b want 0 1 0 0 1",
                      count, empty, overflow, underflow, almost_empty);
    end
    #1;
    rst_n = 1'b1;
    do_cycle(1'b1, 1'b0, 8'h77, 1'b0);
    total++;
    if ({read_data, count} !== {8'h77, 4'd1}) begin
      bad++; $display("FAIL ar_post: got rd=%h cnt=%0d want 77 1", read_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_errors();
    test_empty_simul();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
